// File: rtl/mod_mips_memory_responder.sv
// rtl/mod_mips_memory_responder.sv - unified instruction/data memory with byte-stream image loader for a single-cycle MIPS core
module mod_mips_memory_responder #(
    parameter int DEPTH_WORDS = 256
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc,
    input  logic [31:0] data_address,
    input  logic [31:0] store_data,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic        load_valid,
    input  logic [7:0]  load_byte,
    input  logic        load_done,
    output logic [31:0] instruction,
    output logic [31:0] data,
    output logic        hold_core,
    output logic        load_overflow,
    output logic        addr_error
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam logic [AW:0] DEPTH_PTR = (AW + 1)'(DEPTH_WORDS);
    localparam logic [AW:0] PTR_ONE   = (AW + 1)'(1);

    typedef enum logic {
        ST_LOAD,
        ST_RUN
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] mem [DEPTH_WORDS];

    logic [AW:0] load_ptr_q, load_ptr_d;
    logic [1:0]  byte_cnt_q, byte_cnt_d;
    logic [31:0] asm_q, asm_d;
    logic        overflow_q, overflow_d;
    logic        error_q, error_d;

    logic          mem_we;
    logic [AW-1:0] mem_waddr;
    logic [31:0]   mem_wdata;

    logic          pc_valid, da_valid;
    logic [AW-1:0] pc_idx, da_idx;

    // Byte stream state as it would look after accepting this cycle's byte
    logic [31:0] asm_next;
    logic [2:0]  cnt_next;
    logic [31:0] partial_word;

    // An address is usable only when word-aligned and inside the array
    assign pc_valid = (pc[1:0] == 2'b00) && (pc[31:AW+2] == '0);
    assign da_valid = (data_address[1:0] == 2'b00) && (data_address[31:AW+2] == '0);
    assign pc_idx   = pc[AW+1:2];
    assign da_idx   = data_address[AW+1:2];

    // Zero-latency read ports; invalid addresses read as zero
    assign instruction = pc_valid ? mem[pc_idx] : 32'h0;
    assign data        = da_valid ? mem[da_idx] : 32'h0;

    assign hold_core     = (state_q == ST_LOAD);
    assign load_overflow = overflow_q;
    assign addr_error    = error_q;

    // Next-state, loader assembly and the single memory write port
    always_comb begin
        state_d      = state_q;
        load_ptr_d   = load_ptr_q;
        byte_cnt_d   = byte_cnt_q;
        asm_d        = asm_q;
        overflow_d   = overflow_q;
        error_d      = error_q;
        mem_we       = 1'b0;
        mem_waddr    = load_ptr_q[AW-1:0];
        asm_next     = load_valid ? {asm_q[23:0], load_byte} : asm_q;
        cnt_next     = {1'b0, byte_cnt_q} + {2'b00, load_valid};
        mem_wdata    = asm_next;

        // A partial word keeps its first byte in the top lane, low lanes zero
        case (cnt_next)
            3'd1:    partial_word = {asm_next[7:0], 24'h0};
            3'd2:    partial_word = {asm_next[15:0], 16'h0};
            3'd3:    partial_word = {asm_next[23:0], 8'h0};
            default: partial_word = asm_next;
        endcase

        case (state_q)
            ST_LOAD: begin
                if (cnt_next == 3'd4 || (load_done && cnt_next != 3'd0)) begin
                    mem_wdata = (cnt_next == 3'd4) ? asm_next : partial_word;
                    if (load_ptr_q < DEPTH_PTR) begin
                        mem_we     = 1'b1;
                        load_ptr_d = load_ptr_q + PTR_ONE;
                    end else begin
                        overflow_d = 1'b1;
                    end
                    byte_cnt_d = 2'b00;
                    asm_d      = 32'h0;
                end else begin
                    byte_cnt_d = cnt_next[1:0];
                    asm_d      = asm_next;
                end
                if (load_done) begin
                    state_d    = ST_RUN;
                    byte_cnt_d = 2'b00;
                    asm_d      = 32'h0;
                end
            end
            ST_RUN: begin
                mem_waddr = da_idx;
                mem_wdata = store_data;
                if (mem_write && da_valid) begin
                    mem_we = 1'b1;
                end
                if (!pc_valid || (!da_valid && (mem_read || mem_write))) begin
                    error_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_LOAD;
            end
        endcase

        // Reset drops any in-flight write, including a partial loader word
        if (!reset) begin
            mem_we = 1'b0;
        end
    end

    // Control state registers
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= ST_LOAD;
            load_ptr_q <= '0;
            byte_cnt_q <= 2'b00;
            asm_q      <= 32'h0;
            overflow_q <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            load_ptr_q <= load_ptr_d;
            byte_cnt_q <= byte_cnt_d;
            asm_q      <= asm_d;
            overflow_q <= overflow_d;
            error_q    <= error_d;
        end
    end

    // Memory array; contents survive reset so a loaded image can be rerun
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

endmodule

// File: tb/tb_mod_mips_memory_responder.sv
// tb/tb_mod_mips_memory_responder.sv - randomized self-checking bench for mod_mips_memory_responder
module tb_mod_mips_memory_responder;

    localparam int DW = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc, data_address, store_data;
    logic        mem_read, mem_write, load_valid, load_done;
    logic [7:0]  load_byte;
    logic [31:0] instruction, data;
    logic        hold_core, load_overflow, addr_error;

    int checks = 0;
    int errors = 0;

    logic [31:0] mm [DW];
    bit          m_ovf, m_err;

    always #5 clk = ~clk;

    mod_mips_memory_responder #(.DEPTH_WORDS(DW)) dut (
        .clk          (clk),
        .reset        (reset),
        .pc           (pc),
        .data_address (data_address),
        .store_data   (store_data),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .load_valid   (load_valid),
        .load_byte    (load_byte),
        .load_done    (load_done),
        .instruction  (instruction),
        .data         (data),
        .hold_core    (hold_core),
        .load_overflow(load_overflow),
        .addr_error   (addr_error)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %08h expected %08h", tag, got, exp);
        end
    endtask

    function automatic bit addr_ok(input logic [31:0] a);
        return (a % 4 == 0) && (a < 4 * DW);
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] a);
        if (addr_ok(a)) return mm[(a / 4) % DW];
        return 32'h0;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        pc = 0; data_address = 0; store_data = 0;
        mem_read = 0; mem_write = 0;
        load_valid = 0; load_byte = 0; load_done = 0;
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b0;
        step();
        check_eq("rst_hold", hold_core, 1);
        check_eq("rst_ovf", load_overflow, 0);
        check_eq("rst_err", addr_error, 0);
        reset = 1'b1;
        m_ovf = 0;
        m_err = 0;
    endtask

    // Streams an image; the model packs it into big-endian words afterwards
    task automatic load_image(input logic [7:0] b[$], input bit done_sep);
        int n = b.size();
        int nwords = (n + 3) / 4;
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(0, 2)) step();
            load_valid = 1'b1;
            load_byte  = b[i];
            load_done  = (i == n - 1) && !done_sep;
            if (load_done) begin
                @(negedge clk);
                check_eq("hold_before_done", hold_core, 1);
            end
            step();
            load_valid = 1'b0;
            load_done  = 1'b0;
        end
        if (done_sep || n == 0) begin
            load_done = 1'b1;
            @(negedge clk);
            check_eq("hold_before_done", hold_core, 1);
            step();
            load_done = 1'b0;
        end
        for (int w = 0; w < nwords; w++) begin
            logic [31:0] word = 32'h0;
            for (int k = 0; k < 4; k++) begin
                int j = 4 * w + k;
                word = (word << 8) | ((j < n) ? 32'(b[j]) : 32'h0);
            end
            if (w < DW) mm[w] = word;
            else        m_ovf = 1;
        end
        check_eq("hold_after_done", hold_core, 0);
        check_eq("load_overflow", load_overflow, 32'(m_ovf));
    endtask

    task automatic read_word(input int idx);
        pc = idx * 4;
        data_address = idx * 4;
        @(negedge clk);
        check_eq($sformatf("rd_data[%0d]", idx), data, mm[idx]);
        check_eq($sformatf("rd_instr[%0d]", idx), instruction, mm[idx]);
        step();
    endtask

    task automatic run_op(input logic [31:0] p, input logic [31:0] da, input bit rd, input bit wr,
                          input logic [31:0] sd);
        pc = p; data_address = da; mem_read = rd; mem_write = wr; store_data = sd;
        load_valid = 1'($urandom); load_byte = 8'($urandom); load_done = 1'($urandom);
        @(negedge clk);
        check_eq("run_instr", instruction, model_read(p));
        check_eq("run_data", data, model_read(da));
        step();
        if (wr && addr_ok(da)) mm[(da / 4) % DW] = sd;
        if (!addr_ok(p) || (!addr_ok(da) && (rd || wr))) m_err = 1;
        check_eq("run_addr_error", addr_error, 32'(m_err));
        check_eq("run_hold", hold_core, 0);
        check_eq("run_ovf", load_overflow, 32'(m_ovf));
        idle();
    endtask

    function automatic logic [31:0] pick_addr(input bit allow_bad);
        int r = allow_bad ? $urandom_range(0, 9) : 0;
        if (r < 7)  return 32'($urandom_range(0, DW - 1) * 4);
        if (r == 7) return 32'($urandom_range(0, DW - 1) * 4 + $urandom_range(1, 3));
        if (r == 8) return 32'(4 * DW + $urandom_range(0, 1000) * 4);
        return $urandom;
    endfunction

    initial begin
        logic [7:0] img[$];
        idle();
        reset = 1'b1;
        do_reset();

        img = '{8'h8C, 8'h01, 8'h00, 8'h04, 8'h20, 8'h42, 8'h00, 8'h01};
        load_image(img, 1'b1);
        check_eq("img0_const", mm[0], 32'h8C010004);
        read_word(0);
        read_word(1);

        do_reset();
        img = '{8'hAA, 8'hBB};
        load_image(img, 1'b0);
        check_eq("partial_const", mm[0], 32'hAABB0000);
        read_word(0);
        read_word(1);

        do_reset();
        img = {};
        for (int i = 0; i < 68; i++) img.push_back(8'($urandom));
        load_image(img, 1'b1);
        check_eq("ovf_flag_set", load_overflow, 1);
        for (int i = 0; i < DW; i++) read_word(i);

        run_op(0, 32'h10, 0, 1, 32'hDEADBEEF);
        run_op(0, 32'h10, 1, 0, 32'h0);
        check_eq("deadbeef_const", mm[4], 32'hDEADBEEF);

        for (int i = 0; i < 120; i++)
            run_op(pick_addr(0), pick_addr(0), 1'($urandom), 1'($urandom), $urandom);

        run_op(32'h6, 0, 0, 0, 0);
        check_eq("pc6_err", addr_error, 1);
        run_op(0, 0, 1, 0, 0);

        do_reset();
        for (int i = 0; i < DW; i++) read_word(i);
        img = {};
        load_image(img, 1'b1);
        run_op(0, 4 * DW, 1, 0, 0);
        check_eq("oor_err", addr_error, 1);

        do_reset();
        load_image(img, 1'b1);
        run_op(0, 32'h3, 0, 1, 32'h12345678);
        run_op(0, 0, 1, 0, 0);

        do_reset();
        load_valid = 1'b1; load_byte = 8'h11; step();
        load_byte = 8'h22; step();
        load_valid = 1'b0;
        do_reset();
        load_image(img, 1'b1);
        run_op(0, 0, 1, 0, 0);

        for (int t = 0; t < 4; t++) begin
            do_reset();
            img = {};
            repeat ($urandom_range(0, 20)) img.push_back(8'($urandom));
            load_image(img, 1'($urandom));
            for (int i = 0; i < 30; i++)
                run_op(pick_addr(0), pick_addr(0), 1'($urandom), 1'($urandom), $urandom);
        end

        for (int i = 0; i < 80; i++)
            run_op(pick_addr(1), pick_addr(1), 1'($urandom), 1'($urandom), $urandom);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mod_mips_memory_responder.md
MOD_MIPS_MEMORY_RESPONDER -- requirements
Module: mod_mips_memory_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 256, meaning the number of 32-bit words of unified instruction/data memory (power of two, 16..1024).
REQ-002 SHALL have port clk  input  1  the single clock; all state updates occur on its rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
REQ-004 SHALL have port pc  input  32  instruction fetch byte address, driven by the core's rg_pc.
REQ-005 SHALL have port data_address  input  32  data access byte address, driven by the core.
REQ-006 SHALL have port store_data  input  32  write data for a store.
REQ-007 SHALL have port mem_read  input  1  data read strobe.
REQ-008 SHALL have port mem_write  input  1  data write strobe.
REQ-009 SHALL have port load_valid  input  1  loader byte strobe.
REQ-010 SHALL have port load_byte  input  8  loader byte.
REQ-011 SHALL have port load_done  input  1  loader end-of-image strobe.
REQ-012 SHALL have port instruction  output  32  word at pc.
REQ-013 SHALL have port data  output  32  word at data_address.
REQ-014 SHALL have port hold_core  output  1  high while the core must be held in reset.
REQ-015 SHALL have port load_overflow  output  1  sticky flag: the image exceeded DEPTH_WORDS.
REQ-016 SHALL have port addr_error  output  1  sticky flag: misaligned or out-of-range access in RUN.

Function
REQ-017 SHALL implement a two-state FSM, LOAD and RUN; reset enters LOAD.
REQ-018 SHALL decode word index = address[log2(DEPTH_WORDS)+1 : 2]; an address is valid iff address[1:0]==0 and address < 4*DEPTH_WORDS.
REQ-019 SHALL drive instruction combinationally from the array at pc when pc is valid, else 0 (zero latency, single-cycle core).
REQ-020 SHALL drive data combinationally from the array at data_address when data_address is valid, else 0, independent of mem_read.
REQ-021 LOAD: hold_core=1; each load_valid byte SHALL shift into a word assembly register big-endian (first byte -> bits 31:24); the byte counter is 0..3.
REQ-022 LOAD: on the 4th byte, the assembled word SHALL be written at load_ptr on that edge, load_ptr increments, and the byte counter clears.
REQ-023 LOAD: when load_ptr == DEPTH_WORDS, further completed words SHALL be discarded, load_ptr SHALL not wrap, and load_overflow SHALL set.
REQ-024 LOAD: load_done SHALL move the FSM to RUN on the same edge; a partial word (counter 1..3) SHALL be written zero-filled in its low bytes, subject to REQ-023.
REQ-025 load_valid and load_done asserted in the same cycle SHALL accept the byte first, then apply REQ-024 including that byte.
REQ-026 RUN: hold_core=0; load_valid and load_done SHALL be ignored.
REQ-027 RUN: mem_write with valid data_address SHALL write store_data on the edge; the same-cycle read returns the old word; the new word is visible the cycle after.
REQ-028 RUN: invalid pc, or invalid data_address with mem_read or mem_write high, SHALL set addr_error on the next edge; the write is suppressed.
REQ-029 mem_write SHALL be ignored in LOAD.

Reset
REQ-030 Reset SHALL set: FSM=LOAD, load_ptr=0, byte counter=0, assembly register=0, load_overflow=0, addr_error=0; hold_core=1 from the cycle reset is sampled.
REQ-031 Reset SHALL NOT clear memory contents; reset asserted mid-RUN or mid-LOAD SHALL discard any partial word.

Verification
REQ-032 Reset, bytes 8C,01,00,04 then 20,42,00,01, load_done -> mem[0]=8C010004, mem[1]=20420001, hold_core falls the cycle after load_done.
REQ-033 Bytes AA,BB with load_done on the 2nd byte -> mem[0]=AABB0000, state RUN next cycle.
REQ-034 DEPTH_WORDS=16, 68 bytes loaded -> mem[0..15] written, word 17 dropped, load_overflow=1.
REQ-035 RUN, mem_write at 0x10 with 0xDEADBEEF -> data reads the old value in the write cycle and 0xDEADBEEF the next cycle.
REQ-036 RUN, pc=0x6 or mem_read at 4*DEPTH_WORDS -> read returns 0, addr_error=1 and stays 1; mem_write at 0x3 leaves memory unchanged.
REQ-037 Reset pulsed mid-RUN -> LOAD, hold_core=1, flags 0, previously loaded words still readable.
